// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - shared widths, watchdog limit, FSM encoding and load helper
package memory_access_stage_pkg;

   localparam int WORD_WIDTH           = 32;
   localparam int REGISTER_INDEX_WIDTH = 5;
   localparam int TIMEOUT_CYCLES       = 64;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_t;

   // Byte loads return the low byte zero-extended; word loads pass through.
   function automatic logic [WORD_WIDTH-1:0] load_extract(
      input logic                  byte_op,
      input logic [WORD_WIDTH-1:0] rdata
   );
      return byte_op ? {{(WORD_WIDTH-8){1'b0}}, rdata[7:0]} : rdata;
   endfunction

endpackage

// File: rtl/mem_watchdog_counter.sv
// rtl/mem_watchdog_counter.sv - counts access cycles, flags the last permitted cycle
module mem_watchdog_counter #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   // expired is high during the LIMIT-th enabled cycle so the owner can abort at its end.
   assign expired = (count == CW'(LIMIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - pipeline MEM stage: data-cache handshake, fault checks, MEM/WB outputs
module memory_access_stage
   import memory_access_stage_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            valid_in,
   input  logic [WORD_WIDTH-1:0]           instruction_in,
   input  logic [WORD_WIDTH-1:0]           alu_result_in,
   input  logic [WORD_WIDTH-1:0]           store_data_in,
   input  logic                            cu_mem_read_in,
   input  logic                            cu_mem_write_in,
   input  logic                            cu_mem_to_reg_in,
   input  logic                            cu_reg_write_in,
   input  logic                            cu_byte_op_in,
   input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
   output logic                            dcache_req_out,
   output logic                            dcache_we_out,
   output logic                            dcache_byte_out,
   output logic [WORD_WIDTH-1:0]           dcache_addr_out,
   output logic [WORD_WIDTH-1:0]           dcache_wdata_out,
   input  logic                            dcache_op_done_in,
   input  logic [WORD_WIDTH-1:0]           dcache_rdata_in,
   output logic                            valid_out,
   output logic                            cu_mem_to_reg_out,
   output logic                            cu_reg_write_out,
   output logic                            dcache_op_done_out,
   output logic [WORD_WIDTH-1:0]           instruction_out,
   output logic [WORD_WIDTH-1:0]           dst_reg_data_out,
   output logic [REGISTER_INDEX_WIDTH-1:0] destination_register_out,
   output logic                            stall_out,
   output logic                            mem_error_out
);

   mem_state_t                      state;
   logic                            mem_op;
   logic                            fault;
   logic                            expired;
   logic [WORD_WIDTH-1:0]           lat_instr;
   logic [REGISTER_INDEX_WIDTH-1:0] lat_rd;
   logic                            lat_mem_to_reg;
   logic                            lat_reg_write;

   assign mem_op = cu_mem_read_in | cu_mem_write_in;
   assign fault  = (cu_mem_read_in & cu_mem_write_in) |
                   (!cu_byte_op_in && (alu_result_in[1:0] != 2'b00));

   // Faulting ops retire in one cycle, so they never freeze upstream.
   always_comb begin
      stall_out = 1'b0;
      if (!rst) begin
         if (state == ST_IDLE)
            stall_out = valid_in & mem_op & !fault;
         else
            stall_out = !dcache_op_done_in;
      end
   end

   mem_watchdog_counter #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == ST_IDLE),
      .enable (state == ST_ACCESS),
      .expired(expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                    <= ST_IDLE;
         dcache_req_out           <= 1'b0;
         dcache_we_out            <= 1'b0;
         dcache_byte_out          <= 1'b0;
         dcache_addr_out          <= '0;
         dcache_wdata_out         <= '0;
         valid_out                <= 1'b0;
         cu_mem_to_reg_out        <= 1'b0;
         cu_reg_write_out         <= 1'b0;
         dcache_op_done_out       <= 1'b0;
         instruction_out          <= '0;
         dst_reg_data_out         <= '0;
         destination_register_out <= '0;
         mem_error_out            <= 1'b0;
         lat_instr                <= '0;
         lat_rd                   <= '0;
         lat_mem_to_reg           <= 1'b0;
         lat_reg_write            <= 1'b0;
      end else begin
         valid_out          <= 1'b0;
         dcache_op_done_out <= 1'b0;
         if (state == ST_IDLE) begin
            if (valid_in) begin
               if (!mem_op) begin
                  valid_out                <= 1'b1;
                  dst_reg_data_out         <= alu_result_in;
                  cu_mem_to_reg_out        <= cu_mem_to_reg_in;
                  cu_reg_write_out         <= cu_reg_write_in;
                  destination_register_out <= destination_register_in;
                  instruction_out          <= instruction_in;
               end else if (fault) begin
                  valid_out                <= 1'b1;
                  mem_error_out            <= 1'b1;
                  dst_reg_data_out         <= alu_result_in;
                  cu_mem_to_reg_out        <= 1'b0;
                  cu_reg_write_out         <= 1'b0;
                  destination_register_out <= destination_register_in;
                  instruction_out          <= instruction_in;
               end else begin
                  state            <= ST_ACCESS;
                  dcache_req_out   <= 1'b1;
                  dcache_we_out    <= cu_mem_write_in;
                  dcache_byte_out  <= cu_byte_op_in;
                  dcache_addr_out  <= alu_result_in;
                  dcache_wdata_out <= store_data_in;
                  lat_instr        <= instruction_in;
                  lat_rd           <= destination_register_in;
                  lat_mem_to_reg   <= cu_mem_to_reg_in;
                  lat_reg_write    <= cu_reg_write_in;
               end
            end
         end else begin
            // A done arriving on the watchdog's last cycle still wins.
            if (dcache_op_done_in) begin
               state                    <= ST_IDLE;
               dcache_req_out           <= 1'b0;
               valid_out                <= 1'b1;
               dcache_op_done_out       <= 1'b1;
               instruction_out          <= lat_instr;
               destination_register_out <= lat_rd;
               cu_mem_to_reg_out        <= lat_mem_to_reg;
               cu_reg_write_out         <= lat_reg_write & !dcache_we_out;
               dst_reg_data_out         <= dcache_we_out ? dcache_addr_out
                                           : load_extract(dcache_byte_out, dcache_rdata_in);
            end else if (expired) begin
               state                    <= ST_IDLE;
               dcache_req_out           <= 1'b0;
               mem_error_out            <= 1'b1;
               valid_out                <= 1'b1;
               instruction_out          <= lat_instr;
               destination_register_out <= lat_rd;
               cu_mem_to_reg_out        <= 1'b0;
               cu_reg_write_out         <= 1'b0;
               dst_reg_data_out         <= dcache_addr_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_memory_access_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] instruction_in = '0;
   logic [31:0] alu_result_in = '0;
   logic [31:0] store_data_in = '0;
   logic        cu_mem_read_in = 1'b0;
   logic        cu_mem_write_in = 1'b0;
   logic        cu_mem_to_reg_in = 1'b0;
   logic        cu_reg_write_in = 1'b0;
   logic        cu_byte_op_in = 1'b0;
   logic [4:0]  destination_register_in = '0;
   logic        dcache_req_out, dcache_we_out, dcache_byte_out;
   logic [31:0] dcache_addr_out, dcache_wdata_out;
   logic        dcache_op_done_in = 1'b0;
   logic [31:0] dcache_rdata_in = '0;
   logic        valid_out, cu_mem_to_reg_out, cu_reg_write_out, dcache_op_done_out;
   logic [31:0] instruction_out, dst_reg_data_out;
   logic [4:0]  destination_register_out;
   logic        stall_out, mem_error_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_access_stage dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .instruction_in(instruction_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .cu_mem_read_in(cu_mem_read_in), .cu_mem_write_in(cu_mem_write_in),
      .cu_mem_to_reg_in(cu_mem_to_reg_in), .cu_reg_write_in(cu_reg_write_in),
      .cu_byte_op_in(cu_byte_op_in), .destination_register_in(destination_register_in),
      .dcache_req_out(dcache_req_out), .dcache_we_out(dcache_we_out),
      .dcache_byte_out(dcache_byte_out), .dcache_addr_out(dcache_addr_out),
      .dcache_wdata_out(dcache_wdata_out), .dcache_op_done_in(dcache_op_done_in),
      .dcache_rdata_in(dcache_rdata_in), .valid_out(valid_out),
      .cu_mem_to_reg_out(cu_mem_to_reg_out), .cu_reg_write_out(cu_reg_write_out),
      .dcache_op_done_out(dcache_op_done_out), .instruction_out(instruction_out),
      .dst_reg_data_out(dst_reg_data_out), .destination_register_out(destination_register_out),
      .stall_out(stall_out), .mem_error_out(mem_error_out)
   );

   typedef struct {
      logic        v, rd, wr, m2r, rw, bop;
      logic [31:0] alu, st, instr;
      logic [4:0]  rdi;
   } op_t;

   typedef struct {
      op_t         op;
      logic        e_valid, e_rw, e_req, e_stall, e_err;
      logic [31:0] e_dst;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input op_t op);
      valid_in = op.v; cu_mem_read_in = op.rd; cu_mem_write_in = op.wr;
      cu_mem_to_reg_in = op.m2r; cu_reg_write_in = op.rw; cu_byte_op_in = op.bop;
      alu_result_in = op.alu; store_data_in = op.st; instruction_in = op.instr;
      destination_register_in = op.rdi;
   endtask

   task automatic do_reset();
      valid_in = 1'b0; dcache_op_done_in = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   // Presents one op, answers the cache after lat access cycles (0 = never), returns when retired.
   task automatic do_op(input op_t op, input int lat, input logic [31:0] rdata,
                        output int stalls, output int reqs);
      stalls = 0; reqs = 0;
      apply(op);
      dcache_op_done_in = 1'b0;
      #1 if (stall_out) stalls++;
      @(posedge clk); #1 valid_in = 1'b0;
      while (dcache_req_out && reqs < 200) begin
         reqs++;
         chk("req_addr_stable", dcache_addr_out, op.alu);
         if (reqs == lat) begin
            dcache_op_done_in = 1'b1; dcache_rdata_in = rdata;
         end
         #1 if (stall_out) stalls++;
         @(posedge clk); #1 dcache_op_done_in = 1'b0;
      end
      if (reqs >= 200) chk("access_budget", 32'(reqs), 32'd0);
   endtask

   function automatic op_t mk(input logic v, rd, wr, bop, rw, input logic [31:0] alu, input logic [4:0] rdi);
      op_t o;
      o.v = v; o.rd = rd; o.wr = wr; o.bop = bop; o.rw = rw; o.m2r = rd;
      o.alu = alu; o.st = 32'hCAFE_0000 | alu; o.instr = 32'h1000_0000 | alu; o.rdi = rdi;
      return o;
   endfunction

   vec_t tbl[8];
   int   st_n, rq_n;

   initial begin
      // Asynchronous reset, checked before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("reset_req", {31'd0, dcache_req_out}, 32'd0);
      chk("reset_valid", {31'd0, valid_out}, 32'd0);
      chk("reset_err", {31'd0, mem_error_out}, 32'd0);
      chk("reset_dst", dst_reg_data_out, 32'd0);
      chk("reset_stall", {31'd0, stall_out}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      //           op                                   valid rw  req stall err  dst
      tbl[0] = '{mk(1,0,0,0,1,32'h2A, 5),               1, 1, 0, 0, 0, 32'h2A};
      tbl[1] = '{mk(1,0,0,0,0,32'h1234, 7),             1, 0, 0, 0, 0, 32'h1234};
      tbl[2] = '{mk(0,0,0,0,1,32'h55, 3),               0, 0, 0, 0, 0, 32'h0};
      tbl[3] = '{mk(1,0,1,0,1,32'h102, 9),              1, 0, 0, 0, 1, 32'h102};
      tbl[4] = '{mk(1,1,0,0,1,32'h101, 9),              1, 0, 0, 0, 1, 32'h101};
      tbl[5] = '{mk(1,1,1,0,1,32'h100, 9),              1, 0, 0, 0, 1, 32'h100};
      tbl[6] = '{mk(1,1,0,1,1,32'h103, 4),              0, 0, 1, 1, 0, 32'h0};
      tbl[7] = '{mk(1,1,0,0,1,32'h100, 4),              0, 0, 1, 1, 0, 32'h0};
      for (int i = 0; i < 8; i++) begin
         do_reset();
         apply(tbl[i].op);
         #1 chk($sformatf("t%0d_stall", i), {31'd0, stall_out}, {31'd0, tbl[i].e_stall});
         @(posedge clk); #1;
         chk($sformatf("t%0d_valid", i), {31'd0, valid_out}, {31'd0, tbl[i].e_valid});
         chk($sformatf("t%0d_rw", i), {31'd0, cu_reg_write_out}, {31'd0, tbl[i].e_rw});
         chk($sformatf("t%0d_req", i), {31'd0, dcache_req_out}, {31'd0, tbl[i].e_req});
         chk($sformatf("t%0d_err", i), {31'd0, mem_error_out}, {31'd0, tbl[i].e_err});
         chk($sformatf("t%0d_dst", i), dst_reg_data_out, tbl[i].e_dst);
         chk($sformatf("t%0d_rd", i), {27'd0, destination_register_out},
             tbl[i].e_valid ? {27'd0, tbl[i].op.rdi} : 32'd0);
      end

      // Word load, done on the fourth access cycle.
      do_reset();
      do_op(mk(1,1,0,0,1,32'h100,6), 4, 32'hDEADBEEF, st_n, rq_n);
      chk("lw_stalls", 32'(st_n), 32'd4);
      chk("lw_valid", {31'd0, valid_out}, 32'd1);
      chk("lw_dst", dst_reg_data_out, 32'hDEADBEEF);
      chk("lw_done_out", {31'd0, dcache_op_done_out}, 32'd1);
      @(posedge clk); #1;
      chk("lw_done_pulse", {31'd0, dcache_op_done_out}, 32'd0);

      // Byte load at odd address.
      do_op(mk(1,1,0,1,1,32'h103,6), 2, 32'h123456AB, st_n, rq_n);
      chk("lb_dst", dst_reg_data_out, 32'h000000AB);
      chk("lb_rw", {31'd0, cu_reg_write_out}, 32'd1);

      // Aligned word store reports the address and never writes a register.
      do_op(mk(1,0,1,0,1,32'h200,6), 1, 32'h0, st_n, rq_n);
      chk("sw_dst", dst_reg_data_out, 32'h200);
      chk("sw_rw", {31'd0, cu_reg_write_out}, 32'd0);
      chk("sw_err", {31'd0, mem_error_out}, 32'd0);

      // Done pulse while idle is ignored.
      dcache_op_done_in = 1'b1;
      @(posedge clk); #1 dcache_op_done_in = 1'b0;
      chk("idle_done_valid", {31'd0, valid_out}, 32'd0);
      chk("idle_done_out", {31'd0, dcache_op_done_out}, 32'd0);

      // Done on the last watchdog cycle counts as done.
      do_op(mk(1,1,0,0,1,32'h300,2), 64, 32'h0BADF00D, st_n, rq_n);
      chk("edge_reqs", 32'(rq_n), 32'd64);
      chk("edge_dst", dst_reg_data_out, 32'h0BADF00D);
      chk("edge_err", {31'd0, mem_error_out}, 32'd0);

      // Timeout.
      do_op(mk(1,1,0,0,1,32'h400,2), 0, 32'h0, st_n, rq_n);
      chk("to_reqs", 32'(rq_n), 32'd64);
      chk("to_req", {31'd0, dcache_req_out}, 32'd0);
      chk("to_err", {31'd0, mem_error_out}, 32'd1);
      chk("to_stall", {31'd0, stall_out}, 32'd0);
      chk("to_rw", {31'd0, cu_reg_write_out}, 32'd0);

      // Reset on the second access cycle.
      do_reset();
      apply(mk(1,1,0,0,1,32'h500,3));
      @(posedge clk); #1 valid_in = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("rst_req", {31'd0, dcache_req_out}, 32'd0);
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      chk("rst_dst", dst_reg_data_out, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_no_valid", {31'd0, valid_out}, 32'd0);
      do_op(mk(1,0,0,0,1,32'h77,8), 0, 32'h0, st_n, rq_n);
      chk("rst_alu_valid", {31'd0, valid_out}, 32'd1);
      chk("rst_alu_dst", dst_reg_data_out, 32'h77);

      // Random ops against a behavioural model.
      begin
         logic        m_err = 1'b0;
         logic [31:0] m_dst = 32'h77;
         for (int n = 0; n < 60; n++) begin
            op_t         o;
            int          kind, lat;
            logic [31:0] rdata, e_dst;
            logic        memop, flt, ok, e_rw, e_done;
            kind = $urandom_range(0, 4);
            o = mk(kind != 4, kind == 1 || kind == 3, kind == 2 || kind == 3,
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   ($urandom & 32'hFFF0) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0),
                   5'($urandom));
            lat   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
            rdata = $urandom;
            memop = o.rd | o.wr;
            flt   = memop && ((o.rd && o.wr) || (!o.bop && o.alu % 4 != 0));
            ok    = memop && !flt && lat != 0 && lat <= 64;
            e_dst = m_dst; e_rw = 1'b0; e_done = 1'b0;
            if (o.v) begin
               e_dst = o.alu;
               if (!memop) e_rw = o.rw;
               if (ok && o.rd) begin
                  e_rw  = o.rw;
                  e_dst = o.bop ? (rdata & 32'hFF) : rdata;
               end
               e_done = ok;
               if (flt || (memop && !ok)) m_err = 1'b1;
            end
            do_op(o, lat, rdata, st_n, rq_n);
            chk($sformatf("r%0d_valid", n), {31'd0, valid_out}, {31'd0, o.v});
            chk($sformatf("r%0d_dst", n), dst_reg_data_out, e_dst);
            chk($sformatf("r%0d_err", n), {31'd0, mem_error_out}, {31'd0, m_err});
            if (o.v) begin
               chk($sformatf("r%0d_rw", n), {31'd0, cu_reg_write_out}, {31'd0, e_rw});
               chk($sformatf("r%0d_done", n), {31'd0, dcache_op_done_out}, {31'd0, e_done});
               chk($sformatf("r%0d_instr", n), instruction_out, o.instr);
            end
            m_dst = e_dst;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
